// File: rtl/alt_vipvfr121_vfr_control_packet_decoder.sv
// Video frame reader control packet decoder.
// Passes video packets (type 0) through unchanged, decodes control packets
// (type 0xF) into width/height/interlaced, and swallows every other packet.
module alt_vipvfr121_vfr_control_packet_decoder #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic                                        dout_sop,
    output logic                                        dout_eop,
    output logic [15:0]                                 width,
    output logic [15:0]                                 height,
    output logic [3:0]                                  interlaced,
    output logic                                        ctrl_valid,
    output logic                                        ctrl_short
);

    // A control packet body carries 9 nibbles: width (4), height (4), interlaced (1).
    localparam int         NIBBLES  = 9;
    localparam logic [3:0] CNT_MAX  = 4'd9;
    localparam logic [3:0] CNT_STEP = 4'(SYMBOLS_PER_BEAT);

    typedef enum logic [1:0] {
        HEADER,
        CTRL_BODY,
        VIDEO,
        DISCARD
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] shadow     [NIBBLES];
    logic [3:0] shadow_nxt [NIBBLES];
    logic       hdr_beat;
    logic       accept;
    logic       commit;
    logic       short_pkt;
    logic [3:0] pkt_type;
    logic [3:0] k;

    assign pkt_type  = din_data[3:0];
    assign dout_data = din_data;
    assign dout_sop  = din_sop;
    assign dout_eop  = din_eop;

    // Handshake, packet classification, nibble capture and next state.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        // A sop arriving mid control/user packet aborts it and is treated exactly
        // like a sop seen in HEADER, including forwarding and backpressure.
        hdr_beat   = (state == HEADER) ||
                     ((state == CTRL_BODY || state == DISCARD) && din_sop);
        din_ready  = 1'b1;
        dout_valid = 1'b0;
        if (hdr_beat) begin
            din_ready  = dout_ready;
            dout_valid = din_valid & din_sop & (pkt_type == 4'h0);
        end else if (state == VIDEO) begin
            din_ready  = dout_ready;
            dout_valid = din_valid;
        end
        accept = din_valid & din_ready;

        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        commit     = 1'b0;
        short_pkt  = 1'b0;
        k          = '0;

        if (accept) begin
            if (hdr_beat) begin
                // Non-sop beats in HEADER are dropped without changing state.
                if (din_sop) begin
                    if (pkt_type == 4'h0) begin
                        state_nxt = din_eop ? HEADER : VIDEO;
                    end else if (pkt_type == 4'hF) begin
                        cnt_nxt   = '0;
                        short_pkt = din_eop;
                        state_nxt = din_eop ? HEADER : CTRL_BODY;
                    end else begin
                        state_nxt = din_eop ? HEADER : DISCARD;
                    end
                end
            end else begin
                case (state)
                    VIDEO: begin
                        if (din_eop) state_nxt = HEADER;
                    end
                    CTRL_BODY: begin
                        for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
                            k = cnt + 4'(s);
                            if (k < CNT_MAX) shadow_nxt[k] = din_data[s*BITS_PER_SYMBOL +: 4];
                        end
                        cnt_nxt = (cnt > CNT_MAX - CNT_STEP) ? CNT_MAX : cnt + CNT_STEP;
                        if (din_eop) begin
                            commit    = (cnt_nxt == CNT_MAX);
                            short_pkt = (cnt_nxt != CNT_MAX);
                            state_nxt = HEADER;
                        end
                    end
                    DISCARD: begin
                        if (din_eop) state_nxt = HEADER;
                    end
                    default: state_nxt = HEADER;
                endcase
            end
        end
    end

    // State, nibble shadow and committed frame parameters.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HEADER;
            cnt   <= '0;
            // NOTE: the shadow nibbles are reset deliberately; a fresh start must never commit stale values.
            for (int i = 0; i < NIBBLES; i++) shadow[i] <= '0;
            width      <= '0;
            height     <= '0;
            interlaced <= '0;
            ctrl_valid <= 1'b0;
            ctrl_short <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shadow     <= shadow_nxt;
            ctrl_valid <= commit;
            ctrl_short <= short_pkt;
            if (commit) begin
                width      <= {shadow_nxt[0], shadow_nxt[1], shadow_nxt[2], shadow_nxt[3]};
                height     <= {shadow_nxt[4], shadow_nxt[5], shadow_nxt[6], shadow_nxt[7]};
                interlaced <= shadow_nxt[8];
            end
        end
    end

endmodule

// File: tb/tb_alt_vipvfr121_vfr_control_packet_decoder.sv
// Scoreboard bench for the control packet decoder: packets are modelled at
// packet level (forwarded beats, decoded nibbles) and a monitor compares the
// DUT's source beats and ctrl pulses against the queued expectations.
`timescale 1ns/1ps
module tb_alt_vipvfr121_vfr_control_packet_decoder;

    localparam int BPS = 8;
    localparam int SPB = 3;
    localparam int W   = BPS * SPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_ready;
    logic          din_valid = 1'b0;
    logic [W-1:0]  din_data = '0;
    logic          din_sop = 1'b0;
    logic          din_eop = 1'b0;
    logic          dout_ready = 1'b0;
    logic          dout_valid;
    logic [W-1:0]  dout_data;
    logic          dout_sop;
    logic          dout_eop;
    logic [15:0]   width;
    logic [15:0]   height;
    logic [3:0]    interlaced;
    logic          ctrl_valid;
    logic          ctrl_short;

    always #5 clk = ~clk;

    alt_vipvfr121_vfr_control_packet_decoder #(
        .BITS_PER_SYMBOL (BPS),
        .SYMBOLS_PER_BEAT(SPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_ready (din_ready),
        .din_valid (din_valid),
        .din_data  (din_data),
        .din_sop   (din_sop),
        .din_eop   (din_eop),
        .dout_ready(dout_ready),
        .dout_valid(dout_valid),
        .dout_data (dout_data),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .width     (width),
        .height    (height),
        .interlaced(interlaced),
        .ctrl_valid(ctrl_valid),
        .ctrl_short(ctrl_short)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
    } beat_t;

    typedef struct packed {
        logic        is_short;
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0]  il;
    } ctrl_t;

    beat_t       exp_beats[$];
    ctrl_t       exp_ctrl[$];
    beat_t       pkt[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] cur_w  = '0;
    logic [15:0] cur_h  = '0;
    logic [3:0]  cur_il = '0;
    logic        seen_ready;
    beat_t       mon_b;
    ctrl_t       mon_c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [W-1:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        return b;
    endfunction

    // Monitor: every source handshake and every ctrl pulse consumes one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid && dout_ready) begin
                check("dout beat expected", 64'(exp_beats.size() > 0), 64'd1);
                if (exp_beats.size() > 0) begin
                    mon_b = exp_beats.pop_front();
                    check("dout_data", 64'(dout_data), 64'(mon_b.data));
                    check("dout_sop", 64'(dout_sop), 64'(mon_b.sop));
                    check("dout_eop", 64'(dout_eop), 64'(mon_b.eop));
                end
            end
            if (ctrl_valid || ctrl_short) begin
                check("ctrl event expected", 64'(exp_ctrl.size() > 0), 64'd1);
                if (exp_ctrl.size() > 0) begin
                    mon_c = exp_ctrl.pop_front();
                    check("ctrl_short", 64'(ctrl_short), 64'(mon_c.is_short));
                    check("ctrl_valid", 64'(ctrl_valid), 64'(!mon_c.is_short));
                    check("width", 64'(width), 64'(mon_c.w));
                    check("height", 64'(height), 64'(mon_c.h));
                    check("interlaced", 64'(interlaced), 64'(mon_c.il));
                end
            end
        end
    end

    // Packet-level reference: video packets are echoed; a terminated control
    // packet commits its first 9 body nibbles or, lacking them, is reported short;
    // unterminated (aborted) and user packets produce nothing.
    task automatic model_pkt();
        logic [3:0]   t;
        logic [3:0]   nib[$];
        logic [W-1:0] d;
        ctrl_t        c;
        t = pkt[0].data[3:0];
        if (t == 4'h0) begin
            foreach (pkt[i]) exp_beats.push_back(pkt[i]);
        end else if (t == 4'hF && pkt[pkt.size()-1].eop) begin
            for (int i = 1; i < pkt.size(); i++) begin
                d = pkt[i].data;
                for (int s = 0; s < SPB; s++) nib.push_back(d[s*BPS +: 4]);
            end
            if (nib.size() >= 9) begin
                cur_w  = {nib[0], nib[1], nib[2], nib[3]};
                cur_h  = {nib[4], nib[5], nib[6], nib[7]};
                cur_il = nib[8];
                c.is_short = 1'b0;
            end else begin
                c.is_short = 1'b1;
            end
            c.w  = cur_w;
            c.h  = cur_h;
            c.il = cur_il;
            exp_ctrl.push_back(c);
        end
    endtask

    // One clock of stimulus. rdy: -1 random, -2 toggle, 0/1 fixed.
    task automatic cyc(input bit v, input beat_t b, input int rdy, output bit acc);
        din_valid = v;
        din_data  = b.data;
        din_sop   = b.sop;
        din_eop   = b.eop;
        if (rdy == -1)      dout_ready = 1'($urandom_range(0, 1));
        else if (rdy == -2) dout_ready = ~dout_ready;
        else                dout_ready = rdy[0];
        @(negedge clk);
        seen_ready = din_ready;
        acc = din_valid && din_ready;
        @(posedge clk);
        #1;
    endtask

    // Present one beat until accepted. want: 0 none, 1 din_ready must be 1, 2 must mirror dout_ready.
    task automatic drive(input beat_t b, input int rdy, input int want);
        bit acc;
        bit junk;
        int budget;
        acc    = 1'b0;
        budget = 0;
        if (rdy == -1) repeat ($urandom_range(0, 2)) cyc(1'b0, b, -1, junk);
        while (!acc) begin
            cyc(1'b1, b, rdy, acc);
            if (want == 2) check("din_ready mirrors dout_ready", 64'(seen_ready), 64'(dout_ready));
            if (want == 1) check("din_ready high in body", 64'(seen_ready), 64'd1);
            budget++;
            if (budget >= 200) begin
                check("beat accepted within budget", 64'(acc), 64'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bit junk;
        repeat (n) cyc(1'b0, mk('0, 1'b0, 1'b0), 1, junk);
    endtask

    task automatic send_pkt(input int rdy, input int want);
        model_pkt();
        foreach (pkt[i]) drive(pkt[i], rdy, want);
    endtask

    task automatic gen_random(input int kind, input bit abort);
        int nb;
        pkt.delete();
        case (kind)
            0: begin
                nb = $urandom_range(1, 5);
                pkt.push_back(mk({20'($urandom), 4'h0}, 1'b1, nb == 1));
                for (int i = 1; i < nb; i++)
                    pkt.push_back(mk(24'($urandom), $urandom_range(0, 7) == 0, i == nb - 1));
            end
            1, 2: begin
                nb = (kind == 1) ? $urandom_range(4, 6) : $urandom_range(1, 3);
                pkt.push_back(mk({20'($urandom), 4'hF}, 1'b1, nb == 1 && !abort));
                for (int i = 1; i < nb; i++)
                    pkt.push_back(mk(24'($urandom), 1'b0, i == nb - 1 && !abort));
            end
            default: begin
                nb = $urandom_range(1, 4);
                pkt.push_back(mk({20'($urandom), 4'($urandom_range(1, 14))}, 1'b1, nb == 1 && !abort));
                for (int i = 1; i < nb; i++)
                    pkt.push_back(mk(24'($urandom), 1'b0, i == nb - 1 && !abort));
            end
        endcase
        send_pkt(-1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_abort;
        bit abort;
        int kind;

        // Reset state.
        #22;
        check("reset width", 64'(width), 64'd0);
        check("reset height", 64'(height), 64'd0);
        check("reset interlaced", 64'(interlaced), 64'd0);
        check("reset ctrl_valid", 64'(ctrl_valid), 64'd0);
        check("reset ctrl_short", 64'(ctrl_short), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Stray non-sop beats in HEADER are dropped.
        drive(mk(24'h123450, 1'b0, 1'b1), 1, 2);

        // 640x480 progressive control packet.
        pkt.delete();
        pkt.push_back(mk(24'h00000F, 1'b1, 1'b0));
        pkt.push_back(mk(24'h080200, 1'b0, 1'b0));
        pkt.push_back(mk(24'h010000, 1'b0, 1'b0));
        pkt.push_back(mk(24'h00000E, 1'b0, 1'b1));
        send_pkt(1, 0);
        idle(2);
        check("640x480 width", 64'(width), 64'd640);
        check("640x480 height", 64'(height), 64'd480);
        check("640x480 interlaced", 64'(interlaced), 64'd0);

        // Truncated control packet leaves the committed values alone.
        pkt.delete();
        pkt.push_back(mk(24'h00000F, 1'b1, 1'b0));
        pkt.push_back(mk(24'h080200, 1'b0, 1'b1));
        send_pkt(1, 0);
        idle(2);
        check("short keeps width", 64'(width), 64'd640);
        check("short keeps height", 64'(height), 64'd480);

        // Video packet under toggling backpressure.
        dout_ready = 1'b0;
        pkt.delete();
        pkt.push_back(mk(24'h000000, 1'b1, 1'b0));
        pkt.push_back(mk(24'h123456, 1'b0, 1'b0));
        pkt.push_back(mk(24'hABCDEF, 1'b0, 1'b1));
        send_pkt(-2, 2);
        idle(1);

        // User packet type 5: header needs the source ready, body is consumed regardless.
        pkt.delete();
        pkt.push_back(mk(24'h000005, 1'b1, 1'b0));
        pkt.push_back(mk(24'h111111, 1'b0, 1'b0));
        pkt.push_back(mk(24'h222222, 1'b0, 1'b1));
        model_pkt();
        drive(pkt[0], 1, 0);
        drive(pkt[1], 0, 1);
        drive(pkt[2], 0, 1);
        pkt.delete();
        pkt.push_back(mk(24'h777770, 1'b1, 1'b0));
        pkt.push_back(mk(24'h654321, 1'b0, 1'b1));
        send_pkt(1, 0);

        // Randomized packet stream; an aborted packet is always followed by a
        // control or user packet so the aborting sop never carries video.
        prev_abort = 1'b0;
        for (int n = 0; n < 60; n++) begin
            kind = prev_abort ? $urandom_range(1, 3) : $urandom_range(0, 4);
            if (kind == 4) begin
                repeat ($urandom_range(1, 3)) drive(mk(24'($urandom), 1'b0, 1'($urandom)), -1, 0);
                prev_abort = 1'b0;
            end else begin
                abort = (kind != 0) && ($urandom_range(0, 3) == 0);
                gen_random(kind, abort);
                prev_abort = abort;
            end
        end
        pkt.delete();
        pkt.push_back(mk(24'h0000F0, 1'b1, 1'b1));
        send_pkt(-1, 0);

        // Control packet aborted by a fresh control packet: one commit only.
        pkt.delete();
        pkt.push_back(mk(24'h00000F, 1'b1, 1'b0));
        pkt.push_back(mk(24'h999999, 1'b0, 1'b0));
        send_pkt(1, 0);
        pkt.delete();
        pkt.push_back(mk(24'h00000F, 1'b1, 1'b0));
        pkt.push_back(mk(24'h080200, 1'b0, 1'b0));
        pkt.push_back(mk(24'h010000, 1'b0, 1'b0));
        pkt.push_back(mk(24'h00000E, 1'b0, 1'b1));
        send_pkt(1, 0);
        idle(2);
        check("abort then 640 width", 64'(width), 64'd640);
        check("abort then 480 height", 64'(height), 64'd480);

        // Reset during the second body beat of a video packet.
        exp_beats.push_back(mk(24'h000000, 1'b1, 1'b0));
        exp_beats.push_back(mk(24'h0A0B0C, 1'b0, 1'b0));
        drive(mk(24'h000000, 1'b1, 1'b0), 1, 0);
        drive(mk(24'h0A0B0C, 1'b0, 1'b0), 1, 0);
        din_valid  = 1'b1;
        din_data   = 24'h5A5A5A;
        din_sop    = 1'b0;
        din_eop    = 1'b0;
        dout_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-reset width", 64'(width), 64'd0);
        check("mid-reset height", 64'(height), 64'd0);
        check("mid-reset interlaced", 64'(interlaced), 64'd0);
        check("mid-reset ctrl_valid", 64'(ctrl_valid), 64'd0);
        check("mid-reset ctrl_short", 64'(ctrl_short), 64'd0);
        check("mid-reset dout_valid", 64'(dout_valid), 64'd0);
        cur_w  = '0;
        cur_h  = '0;
        cur_il = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(mk(24'h5A5A5A, 1'b0, 1'b0), 1, 2);
        drive(mk(24'hC3C3C3, 1'b0, 1'b1), 1, 2);
        pkt.delete();
        pkt.push_back(mk(24'h000000, 1'b1, 1'b0));
        pkt.push_back(mk(24'hFEDCBA, 1'b0, 1'b1));
        send_pkt(1, 0);
        idle(4);

        check("all dout beats seen", 64'(exp_beats.size()), 64'd0);
        check("all ctrl events seen", 64'(exp_ctrl.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alt_vipvfr121_vfr_control_packet_decoder.md
ALT_VIPVFR121_VFR_CONTROL_PACKET_DECODER -- requirements
Module: alt_vipvfr121_vfr_control_packet_decoder

Interface
REQ-001 SHALL have parameter BITS_PER_SYMBOL, default 8, bits per symbol.
REQ-002 SHALL have parameter SYMBOLS_PER_BEAT, default 3, symbols per beat; W = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT.
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- din_ready  out  1  sink ready (RL0)
- din_valid  in  1  sink valid
- din_data  in  W  sink data; symbol 0 in bits [BITS_PER_SYMBOL-1:0]
- din_sop  in  1  sink start of packet
- din_eop  in  1  sink end of packet
- dout_ready  in  1  source ready (RL0)
- dout_valid  out  1  source valid
- dout_data  out  W  source data
- dout_sop  out  1  source start of packet
- dout_eop  out  1  source end of packet
- width  out  16  last committed frame width
- height  out  16  last committed frame height
- interlaced  out  4  last committed interlace nibble
- ctrl_valid  out  1  one-cycle pulse on commit
- ctrl_short  out  1  one-cycle pulse on truncated control packet

Function
REQ-004 SHALL define "accept" as din_valid & din_ready at a rising clk edge; packet type = din_data[3:0] of the sop beat.
REQ-005 SHALL implement states HEADER, CTRL_BODY, VIDEO, DISCARD.
REQ-006 In HEADER: din_ready = dout_ready; an accepted beat without sop SHALL be dropped, state unchanged.
REQ-007 In HEADER, accepted sop beat: type 0 -> forwarded, go VIDEO (stay HEADER if eop); type 0xF -> not forwarded, clear symbol counter, go CTRL_BODY (if eop: pulse ctrl_short, stay HEADER); type 1..14 -> not forwarded, go DISCARD (stay HEADER if eop).
REQ-008 In VIDEO: din_ready = dout_ready; dout_valid = din_valid; data/sop/eop passed combinationally unchanged; accepted eop -> HEADER; sop inside VIDEO SHALL be forwarded and not reinterpreted.
REQ-009 In HEADER, dout_valid SHALL be din_valid & din_sop & (din_data[3:0]==0); in CTRL_BODY and DISCARD dout_valid SHALL be 0.
REQ-010 In CTRL_BODY and DISCARD: din_ready = 1 (beats consumed regardless of dout_ready).
REQ-011 In CTRL_BODY each accepted beat SHALL carry symbol indices k = cnt+s, s = 0..SYMBOLS_PER_BEAT-1; for k < 9, low nibble of symbol s SHALL be stored into shadow field k (0..3 = width[15:12]..[3:0], 4..7 = height[15:12]..[3:0], 8 = interlaced); k >= 9 ignored; cnt saturates at 9.
REQ-012 On accepted eop in CTRL_BODY with all 9 nibbles received (including nibbles in the eop beat): width/height/interlaced SHALL update from shadow on that edge, ctrl_valid SHALL pulse for exactly the following cycle, go HEADER.
REQ-013 On accepted eop in CTRL_BODY with fewer than 9 nibbles: outputs unchanged, ctrl_short pulses one cycle, go HEADER.
REQ-014 In CTRL_BODY or DISCARD an accepted sop beat SHALL abort the current packet (no commit, no ctrl_short) and be processed as a HEADER beat in the same cycle.
REQ-015 In DISCARD, accepted eop -> HEADER.
REQ-016 Committed width/height/interlaced SHALL hold until the next successful commit.

Reset
REQ-017 rst_n low SHALL asynchronously force state HEADER, symbol counter 0, shadow and committed width/height/interlaced 0, ctrl_valid 0, ctrl_short 0.
REQ-018 Reset asserted mid-packet SHALL abandon that packet; after release, non-sop beats SHALL be dropped until the next sop.

Verification
REQ-019 Control packet, dout_ready=1: 0x00000F sop; 0x080200; 0x010000; 0x00000E eop -> width=640, height=480, interlaced=0, ctrl_valid one cycle, dout_valid never 1.
REQ-020 Video packet 0x000000 sop, 0x123456, 0xABCDEF eop with dout_ready toggling 1,0,1,... -> identical beats/sop/eop on dout, din_ready mirrors dout_ready, no ctrl_valid.
REQ-021 Control packet 0x00000F sop; 0x080200 eop -> ctrl_short one cycle, width/height unchanged from prior values.
REQ-022 User packet type 0x5 (3 beats) with dout_ready=0 -> all beats after header accepted (din_ready=1), nothing on dout, then video packet passes normally.
REQ-023 Control packet aborted after 1 body beat by new 0x00000F sop then full 640x480 body -> single ctrl_valid, width=640, height=480.
REQ-024 rst_n asserted during VIDEO beat 2 -> outputs zeroed immediately; trailing non-sop beats dropped after release.
